// File: rtl/writeback_regfile_if.sv
// Bundle of write-back stage signals between the memory/decode side (master)
// and the register file (slave). There is no handshake: retire is a
// single-cycle qualifier and is never back-pressured; the commit inputs are
// only looked at in a cycle where retire is 1.
interface writeback_regfile_if #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int CNT_W  = 32
);
  logic              retire;
  logic [3:0]        stat_in;
  logic [ID_W-1:0]   dstE;
  logic [ID_W-1:0]   dstM;
  logic [DATA_W-1:0] valE;
  logic [DATA_W-1:0] valM;
  logic [ID_W-1:0]   srcA;
  logic [ID_W-1:0]   srcB;
  logic [DATA_W-1:0] valA_rd;
  logic [DATA_W-1:0] valB_rd;
  logic [3:0]        cpu_stat;
  logic              running;
  logic [CNT_W-1:0]  retired;

  modport master (
    output retire, stat_in, dstE, dstM, valE, valM, srcA, srcB,
    input  valA_rd, valB_rd, cpu_stat, running, retired
  );

  modport slave (
    input  retire, stat_in, dstE, dstM, valE, valM, srcA, srcB,
    output valA_rd, valB_rd, cpu_stat, running, retired
  );
endinterface

// File: rtl/writeback_regfile.sv
// Y86 SEQ write-back stage: 15-entry register file with two combinational
// read ports, sticky architectural status (RUN / HALTED / FAULT) and a
// retired-instruction counter.
module writeback_regfile #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  writeback_regfile_if.slave    bus,
  output logic [1:0]            state_dbg_o
);

  localparam logic [ID_W-1:0] RNONE    = {ID_W{1'b1}};
  localparam logic [3:0]      STAT_AOK = 4'd1;
  localparam logic [3:0]      STAT_HLT = 4'd2;
  localparam logic [3:0]      STAT_ADR = 4'd3;
  localparam logic [3:0]      STAT_INS = 4'd4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          stat_q, stat_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                commit_en;
  logic [DATA_W-1:0]   regs_q [15];

  // Next-state: only a retire while running can move anything; HALTED and
  // FAULT hold until reset. Unknown stat codes are treated as INS.
  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    retired_d = retired_q;
    commit_en = 1'b0;
    if (state_q == ST_RUN && bus.retire) begin
      case (bus.stat_in)
        STAT_AOK: begin
          commit_en = 1'b1;
          retired_d = retired_q + CNT_W'(1);
        end
        STAT_HLT: begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = ST_HALTED;
          stat_d    = STAT_HLT;
        end
        STAT_ADR: begin
          state_d = ST_FAULT;
          stat_d  = STAT_ADR;
        end
        default: begin
          state_d = ST_FAULT;
          stat_d  = STAT_INS;
        end
      endcase
    end
  end

  // Status/counter registers; reset has priority over any retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      stat_q    <= STAT_AOK;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
    end
  end

  // Register file writes; the dstM write comes last so it wins when both
  // ports target the same register (popq %rsp).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
    end else if (commit_en) begin
      if (bus.dstE != RNONE) regs_q[bus.dstE] <= bus.valE;
      if (bus.dstM != RNONE) regs_q[bus.dstM] <= bus.valM;
    end
  end

  // Read ports see only committed contents; RNONE reads as zero.
  always_comb begin
    bus.valA_rd = (bus.srcA == RNONE) ? '0 : regs_q[bus.srcA];
    bus.valB_rd = (bus.srcB == RNONE) ? '0 : regs_q[bus.srcB];
  end

  assign bus.cpu_stat = stat_q;
  assign bus.running  = (state_q == ST_RUN);
  assign bus.retired  = retired_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: an architectural model of the
// register file/status is checked against the DUT every cycle, and the
// directed sequence pins hand-computed values.
module tb_writeback_regfile;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  writeback_regfile_if #(.DATA_W(64), .ID_W(4), .CNT_W(32)) bus ();

  writeback_regfile #(.DATA_W(64), .ID_W(4), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / check ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- architectural model ----------------
  logic [63:0] mdl_r [15];
  logic [3:0]  mdl_stat;
  logic        mdl_run;
  logic [31:0] mdl_retired;
  logic        mdl_valid = 1'b0;

  function automatic logic [63:0] mdl_read(input logic [3:0] id);
    return (id == 4'hF) ? 64'd0 : mdl_r[id];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (mdl_r[i]) mdl_r[i] = 64'd0;
      mdl_stat    = 4'd1;
      mdl_run     = 1'b1;
      mdl_retired = 32'd0;
      mdl_valid   = 1'b1;
    end else if (mdl_valid && mdl_run && bus.retire) begin
      if (bus.stat_in == 4'd1) begin
        if (bus.dstE != 4'hF) mdl_r[bus.dstE] = bus.valE;
        if (bus.dstM != 4'hF) mdl_r[bus.dstM] = bus.valM;
        mdl_retired = mdl_retired + 1;
      end else if (bus.stat_in == 4'd2) begin
        mdl_retired = mdl_retired + 1;
        mdl_stat    = 4'd2;
        mdl_run     = 1'b0;
      end else begin
        mdl_stat = (bus.stat_in == 4'd3) ? 4'd3 : 4'd4;
        mdl_run  = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (mdl_valid) begin
      check("cyc_valA",    bus.valA_rd,  mdl_read(bus.srcA));
      check("cyc_valB",    bus.valB_rd,  mdl_read(bus.srcB));
      check("cyc_stat",    bus.cpu_stat, mdl_stat);
      check("cyc_running", bus.running,  mdl_run);
      check("cyc_retired", bus.retired,  mdl_retired);
    end
  end

  // ---------------- driver tasks ----------------
  // Every task starts and ends 1 time unit after a rising edge.
  task automatic idle_inputs();
    bus.retire  = 1'b0;
    bus.stat_in = 4'd1;
    bus.dstE    = 4'hF;
    bus.dstM    = 4'hF;
    bus.valE    = 64'd0;
    bus.valM    = 64'd0;
  endtask

  task automatic set_retire(input logic [3:0] st, input logic [3:0] de, input logic [3:0] dm,
                            input logic [63:0] ve, input logic [63:0] vm);
    bus.retire  = 1'b1;
    bus.stat_in = st;
    bus.dstE    = de;
    bus.dstM    = dm;
    bus.valE    = ve;
    bus.valM    = vm;
  endtask

  task automatic retire_one(input logic [3:0] st, input logic [3:0] de, input logic [3:0] dm,
                            input logic [63:0] ve, input logic [63:0] vm);
    set_retire(st, de, dm, ve, vm);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic expect_reg(input string name, input logic [3:0] id, input logic [63:0] exp);
    bus.srcA = id;
    @(negedge clk);
    check(name, bus.valA_rd, exp);
    @(posedge clk); #1;
  endtask

  task automatic expect_status(input string name, input logic [3:0] st, input logic run,
                               input logic [31:0] ret);
    @(negedge clk);
    check({name, "_stat"},    bus.cpu_stat, st);
    check({name, "_running"}, bus.running,  run);
    check({name, "_retired"}, bus.retired,  ret);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.srcA = 4'hF;
    bus.srcB = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state: every register zero, AOK, running, nothing retired.
    for (int i = 0; i < 15; i++) expect_reg("rst_reg", 4'(i), 64'd0);
    expect_status("rst", 4'd1, 1'b1, 32'd0);
    expect_reg("rnone_read", 4'hF, 64'd0);

    // Idle cycle with destinations set but no retire changes nothing.
    bus.dstE = 4'd3; bus.valE = 64'hDEAD;
    @(posedge clk); #1;
    idle_inputs();
    expect_reg("no_retire_r3", 4'd3, 64'd0);

    // Simple valE commit.
    retire_one(4'd1, 4'd3, 4'hF, 64'h1234, 64'd0);
    expect_reg("wr_e_r3", 4'd3, 64'h1234);
    expect_status("wr_e", 4'd1, 1'b1, 32'd1);

    // Both ports to the same register: valM wins.
    retire_one(4'd1, 4'd4, 4'd4, 64'hAA, 64'hBB);
    expect_reg("same_dst_r4", 4'd4, 64'hBB);

    // Distinct E and M destinations in one retire.
    retire_one(4'd1, 4'd8, 4'd9, 64'h8888, 64'h9999);
    expect_reg("dual_r8", 4'd8, 64'h8888);
    expect_reg("dual_r9", 4'd9, 64'h9999);

    // No bypass: read port shows the old value in the write cycle.
    bus.srcB = 4'd5;
    set_retire(4'd1, 4'd5, 4'hF, 64'h77, 64'd0);
    @(negedge clk);
    check("bypass_old_r5", bus.valB_rd, 64'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("bypass_new_r5", bus.valB_rd, 64'h77);
    @(posedge clk); #1;
    bus.srcB = 4'hF;
    expect_status("after_bypass", 4'd1, 1'b1, 32'd4);

    // Reset together with retire: reset wins.
    rst = 1'b1;
    set_retire(4'd1, 4'd6, 4'hF, 64'h99, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    expect_reg("rst_wins_r6", 4'd6, 64'd0);
    expect_reg("rst_wins_r3", 4'd3, 64'd0);
    expect_status("rst_wins", 4'd1, 1'b1, 32'd0);

    // ADR fault: no write, no count, sticky.
    retire_one(4'd1, 4'd2, 4'hF, 64'h11, 64'd0);
    retire_one(4'd3, 4'd2, 4'hF, 64'h55, 64'd0);
    expect_reg("adr_r2", 4'd2, 64'h11);
    expect_status("adr", 4'd3, 1'b0, 32'd1);
    retire_one(4'd1, 4'd7, 4'hF, 64'h1, 64'd0);
    expect_reg("adr_ignored_r7", 4'd7, 64'd0);
    expect_status("adr_sticky", 4'd3, 1'b0, 32'd1);

    // HLT: counted once, then frozen; reset recovers.
    do_reset();
    retire_one(4'd1, 4'd1, 4'hF, 64'h5, 64'd0);
    retire_one(4'd2, 4'd1, 4'hF, 64'h9, 64'd0);
    expect_reg("hlt_r1", 4'd1, 64'h5);
    expect_status("hlt", 4'd2, 1'b0, 32'd2);
    retire_one(4'd1, 4'd1, 4'hF, 64'h8, 64'd0);
    expect_reg("hlt_frozen_r1", 4'd1, 64'h5);
    expect_status("hlt_frozen", 4'd2, 1'b0, 32'd2);
    do_reset();
    expect_reg("hlt_rst_r1", 4'd1, 64'd0);
    expect_status("hlt_rst", 4'd1, 1'b1, 32'd0);

    // Unknown stat code is treated as INS.
    retire_one(4'd7, 4'd10, 4'hF, 64'h3, 64'd0);
    expect_reg("bad_stat_r10", 4'd10, 64'd0);
    expect_status("bad_stat", 4'd4, 1'b0, 32'd0);

    // Explicit INS code.
    do_reset();
    retire_one(4'd4, 4'd11, 4'hF, 64'h3, 64'd0);
    expect_status("ins", 4'd4, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
